adc_sample_fifo: RTL and testbench

Parametrised successor to the quad-ADC frame capture path, running entirely in the AXI_CLK domain downstream of the clock-domain crossing. Accepts one multi-channel sample frame per IN_VALID strobe, applies runtime decimation, and buffers frames in a DEPTH-entry FIFO. Each buffered frame is emitted as NUM_CHANNELS serialised beats on a valid/ready stream. Overflow is reported as a sticky flag plus a saturating drop counter.

---
 rtl/adc_sample_fifo_if.sv | 26 ++
 rtl/adc_sample_fifo.sv | 165 ++++++++++++++++
 tb/tb_adc_sample_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_fifo_if.sv
// Frame-in / beat-out stream bundle for adc_sample_fifo.
// The capture side drives frames in and consumes serialised beats.
interface adc_sample_fifo_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 14
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                               IN_VALID;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] IN_DATA;
  logic                               OUT_VALID;
  logic                               OUT_READY;
  logic [DATA_WIDTH-1:0]              OUT_DATA;
  logic [CH_W-1:0]                    OUT_CHANNEL;
  logic                               OUT_LAST;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  OUT_VALID, OUT_DATA, OUT_CHANNEL, OUT_LAST
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_CHANNEL, OUT_LAST
  );
endinterface

// File: rtl/adc_sample_fifo.sv
// Decimating multi-channel frame FIFO: stores whole frames, replays each
// as NUM_CHANNELS serial beats, and tracks frames lost to a full buffer.
module adc_sample_fifo #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 14,
  parameter int DEPTH_LOG2     = 4,
  parameter int DECIM_WIDTH    = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      AXI_CLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic [DECIM_WIDTH-1:0]    DECIMATION,
  input  logic                      CLEAR_OVERFLOW,
  output logic [DEPTH_LOG2:0]       FIFO_LEVEL,
  output logic                      OVERFLOW,
  output logic [DROP_CNT_WIDTH-1:0] DROP_COUNT,
  adc_sample_fifo_if.slave          bus
);

  localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FRAME_W = NUM_CHANNELS * DATA_WIDTH;
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [0:0]                state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]       level_q, level_d;
  logic [DECIM_WIDTH-1:0]    dec_q, dec_d;
  logic                      ovf_q, ovf_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic [FRAME_W-1:0]    frame_mem [DEPTH];
  logic [DATA_WIDTH-1:0] head_ch   [NUM_CHANNELS];

  logic keep, full, wr_en, discard;
  logic out_valid, beat_acc, is_last, pop;

  // Decimation: reload on a kept frame, count down on skipped ones
  always_comb begin
    dec_d = dec_q;
    keep  = 1'b0;
    if (!ENABLE) begin
      dec_d = '0;
    end else if (bus.IN_VALID) begin
      if (dec_q == '0) begin
        keep  = 1'b1;
        dec_d = DECIMATION;
      end else begin
        dec_d = dec_q - 1'b1;
      end
    end
  end

  // Fullness is judged on the registered level, so a same-cycle pop never frees a slot
  assign full     = (level_q == LVL_FULL);
  assign wr_en    = keep && !full;
  assign discard  = keep && full;

  assign out_valid = (state_q == ST_STREAM);
  assign is_last   = (ch_q == LAST_CH);
  assign beat_acc  = out_valid && bus.OUT_READY;
  assign pop       = beat_acc && is_last;

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_comb begin
    ch_d = ch_q;
    if (beat_acc) begin
      ch_d = is_last ? '0 : ch_q + 1'b1;
    end
  end

  // Looking at the next level lets the first beat appear the cycle after its write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (level_d != '0) state_d = ST_STREAM;
      ST_STREAM: if (pop && level_d == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A discard in the same cycle as a clear leaves one recorded drop
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (discard) begin
      ovf_d  = 1'b1;
      drop_d = CLEAR_OVERFLOW ? DROP_CNT_WIDTH'(1) : sat_inc(drop_q);
    end else if (CLEAR_OVERFLOW) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dec_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dec_q    <= dec_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Frame storage carries no reset; the pointers decide what is valid
  always_ff @(posedge AXI_CLK) begin
    if (wr_en) begin
      frame_mem[wr_ptr_q] <= bus.IN_DATA;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      head_ch[c] = frame_mem[rd_ptr_q][c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.OUT_VALID   = out_valid;
  assign bus.OUT_CHANNEL = ch_q;
  assign bus.OUT_LAST    = out_valid && is_last;
  assign bus.OUT_DATA    = out_valid ? head_ch[ch_q] : '0;

  assign FIFO_LEVEL = level_q;
  assign OVERFLOW   = ovf_q;
  assign DROP_COUNT = drop_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo with a queue-based beat scoreboard.
module tb_adc_sample_fifo;
  localparam int NCH = 4;
  localparam int DW  = 14;
  localparam int DL2 = 4;
  localparam int DCW = 8;
  localparam int DRW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, enable, clear_ovf;
  logic [DCW-1:0] decim;
  logic [DL2:0]   level;
  logic           ovf;
  logic [DRW-1:0] drop;

  adc_sample_fifo_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) bus ();

  adc_sample_fifo #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .DEPTH_LOG2(DL2),
    .DECIM_WIDTH(DCW), .DROP_CNT_WIDTH(DRW)
  ) dut (
    .AXI_CLK(clk), .RESET(rst), .ENABLE(enable), .DECIMATION(decim),
    .CLEAR_OVERFLOW(clear_ovf), .FIFO_LEVEL(level), .OVERFLOW(ovf),
    .DROP_COUNT(drop), .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    ch;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rand_rdy = 1'b0;

  function automatic logic [DW-1:0] fdat(int tag, int c);
    return DW'(tag * 16 + c + 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int tag, bit stored);
    for (int c = 0; c < NCH; c++) begin
      bus.IN_DATA[c*DW +: DW] = fdat(tag, c);
      if (stored) exp_q.push_back('{d: fdat(tag, c), ch: 2'(c), last: (c == NCH - 1)});
    end
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
  endtask

  task automatic drain(int max_cycles, string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: scoreboard pops on every accepted beat; stalled beats must hold
  beat_t         got;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] pd;
  logic [1:0]    pc;
  logic          pl;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(bus.OUT_VALID), 1);
        chk("stall_data",  int'(bus.OUT_DATA), int'(pd));
        chk("stall_ch",    int'(bus.OUT_CHANNEL), int'(pc));
        chk("stall_last",  int'(bus.OUT_LAST), int'(pl));
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got data %0d ch %0d required none",
                   bus.OUT_DATA, bus.OUT_CHANNEL);
        end else begin
          got = exp_q.pop_front();
          chk("beat_data", int'(bus.OUT_DATA), int'(got.d));
          chk("beat_ch",   int'(bus.OUT_CHANNEL), int'(got.ch));
          chk("beat_last", int'(bus.OUT_LAST), int'(got.last));
        end
      end
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
      pd = bus.OUT_DATA;
      pc = bus.OUT_CHANNEL;
      pl = bus.OUT_LAST;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.OUT_READY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; decim = '0; clear_ovf = 1'b0;
    bus.IN_VALID = 1'b0; bus.IN_DATA = '0; bus.OUT_READY = 1'b1;
    repeat (3) tick();

    chk("rst_valid", int'(bus.OUT_VALID), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf",   int'(ovf), 0);
    chk("rst_drop",  int'(drop), 0);
    chk("rst_ch",    int'(bus.OUT_CHANNEL), 0);
    chk("rst_last",  int'(bus.OUT_LAST), 0);
    chk("rst_data",  int'(bus.OUT_DATA), 0);
    rst = 1'b0; enable = 1'b1;
    tick();

    // Basic single frame 1,2,3,4
    send(0, 1'b1);
    chk("basic_valid", int'(bus.OUT_VALID), 1);
    chk("basic_level", int'(level), 1);
    chk("basic_data0", int'(bus.OUT_DATA), 1);
    repeat (4) tick();
    chk("basic_drained",   exp_q.size(), 0);
    chk("basic_level_end", int'(level), 0);
    chk("basic_valid_end", int'(bus.OUT_VALID), 0);

    // Two back-to-back frames: 8 beats on 8 consecutive cycles
    send(1, 1'b1);
    send(2, 1'b1);
    repeat (7) tick();
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_valid",   int'(bus.OUT_VALID), 0);

    // Decimation by 3: frames 0, 3, 6 kept
    decim = 8'd2;
    for (int t = 0; t < 9; t++) send(50 + t, (t % 3) == 0);
    decim = '0;
    drain(200, "decim_drain");
    chk("decim_drop", int'(drop), 0);
    chk("decim_ovf",  int'(ovf), 0);

    // Overflow: 20 frames into 16 slots with output stalled
    bus.OUT_READY = 1'b0;
    for (int t = 0; t < 20; t++) send(20 + t, t < 16);
    chk("ovf_level", int'(level), 16);
    chk("ovf_flag",  int'(ovf), 1);
    chk("ovf_drop",  int'(drop), 4);

    clear_ovf = 1'b1;
    send(60, 1'b0);
    clear_ovf = 1'b0;
    chk("coll_ovf",   int'(ovf), 1);
    chk("coll_drop",  int'(drop), 1);
    chk("coll_level", int'(level), 16);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("clr_ovf",  int'(ovf), 0);
    chk("clr_drop", int'(drop), 0);

    bus.OUT_READY = 1'b1;
    drain(200, "ovf_drain");
    chk("ovf_level_end", int'(level), 0);

    // Random backpressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 6; t++) send(70 + t, 1'b1);
    drain(400, "bp_drain");
    rand_rdy = 1'b0;
    tick();
    bus.OUT_READY = 1'b1;
    tick();
    chk("bp_drop",  int'(drop), 0);
    chk("bp_level", int'(level), 0);

    // Reset in the middle of a frame with 3 frames queued
    send(80, 1'b1);
    send(81, 1'b1);
    send(82, 1'b1);
    chk("rm_level_pre", int'(level), 3);
    chk("rm_ch_pre",    int'(bus.OUT_CHANNEL), 2);
    rst = 1'b1;
    bus.OUT_READY = 1'b0;
    exp_q.delete();
    tick();
    chk("rm_valid", int'(bus.OUT_VALID), 0);
    chk("rm_level", int'(level), 0);
    chk("rm_drop",  int'(drop), 0);
    chk("rm_ch",    int'(bus.OUT_CHANNEL), 0);
    rst = 1'b0;
    bus.OUT_READY = 1'b1;
    tick();
    send(90, 1'b1);
    chk("rm_new_valid", int'(bus.OUT_VALID), 1);
    chk("rm_new_ch",    int'(bus.OUT_CHANNEL), 0);
    chk("rm_new_data",  int'(bus.OUT_DATA), int'(fdat(90, 0)));
    drain(50, "rm_drain");
    repeat (3) tick();
    chk("end_level", int'(level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
